// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receive stage, 8N1 (8E1 with UART_RX_PARITY_EN), 16x oversampling
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : 8E1 frames, PARITY state present, RX_PERR driven
//   undefined : 8N1 frames, RX_PERR tied to 0
//
// Ports:
//   sysclk    in   1  system clock, all logic on rising edge
//   reset     in   1  synchronous active-high reset
//   UART_RX   in   1  asynchronous serial line, idle high
//   RX_DATA   out  8  last correctly received byte
//   RX_STATUS out  1  one-cycle pulse when RX_DATA is updated
//   RX_FERR   out  1  one-cycle pulse on framing error (stop bit sampled 0)
//   RX_PERR   out  1  one-cycle pulse on parity error

module uart_receiver #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       RX_FERR,
  output logic       RX_PERR
);

  // DIV must be at least 1; OVERSAMPLE is fixed at 16 so the tick counter
  // mid/end points below are hard-coded as 7 and 15.
  localparam int               DIV     = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int               DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       tick_cnt, tick_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       data_nxt;
  logic             status_nxt, ferr_nxt;
`ifdef UART_RX_PARITY_EN
  logic             par_bit, par_nxt;
  logic             perr_nxt;
  logic             par_bad;

  // Even parity: the data bits plus the parity bit must XOR to 0.
  assign par_bad = ^{shift, par_bit};
`endif

  assign tick = (div_cnt == DIV_MAX);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      div_cnt   <= '0;
      state     <= S_IDLE;
      tick_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      RX_DATA   <= 8'h00;
      RX_STATUS <= 1'b0;
      RX_FERR   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
      RX_PERR   <= 1'b0;
`endif
    end else begin
      rx_meta   <= UART_RX;
      rx_s      <= rx_meta;
      div_cnt   <= tick ? '0 : div_cnt + 1'b1;
      state     <= state_nxt;
      tick_cnt  <= tick_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      RX_DATA   <= data_nxt;
      RX_STATUS <= status_nxt;
      RX_FERR   <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit   <= par_nxt;
      RX_PERR   <= perr_nxt;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign RX_PERR = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    data_nxt     = RX_DATA;
    status_nxt   = 1'b0;
    ferr_nxt     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt      = par_bit;
    perr_nxt     = 1'b0;
`endif
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state_nxt    = S_START;
            tick_cnt_nxt = 4'd0;
          end
        end
        S_START: begin
          if (tick_cnt == 4'd7) begin
            tick_cnt_nxt = 4'd0;
            bit_cnt_nxt  = 3'd0;
            // A line that is high again by mid start bit was only a glitch.
            state_nxt    = rx_s ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_nxt = tick_cnt + 4'd1;
          end
        end
        S_DATA: begin
          if (tick_cnt == 4'd15) begin
            tick_cnt_nxt       = 4'd0;
            shift_nxt[bit_cnt] = rx_s;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = S_PARITY;
`else
              state_nxt = S_STOP;
`endif
            end else begin
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_cnt == 4'd15) begin
            tick_cnt_nxt = 4'd0;
            par_nxt      = rx_s;
            state_nxt    = S_STOP;
          end else begin
            tick_cnt_nxt = tick_cnt + 4'd1;
          end
        end
`endif
        S_STOP: begin
          if (tick_cnt == 4'd15) begin
            tick_cnt_nxt = 4'd0;
            // Leaving at mid stop bit lets a zero-gap next start edge be seen.
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                perr_nxt = 1'b1;
              end else begin
                data_nxt   = shift;
                status_nxt = 1'b1;
              end
`else
              data_nxt   = shift;
              status_nxt = 1'b1;
`endif
              state_nxt = S_IDLE;
            end else begin
              ferr_nxt  = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_nxt  = par_bad;
`endif
              state_nxt = S_BREAK;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + 4'd1;
          end
        end
        S_BREAK: begin
          // Hold off until the line recovers so a stuck-low line is one error.
          if (rx_s) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver (DIV=4, 64 sysclk/bit)

module tb_uart_receiver;

  logic       sysclk;
  logic       reset;
  logic       UART_RX;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic       RX_FERR;
  logic       RX_PERR;

  int n_cmp = 0;
  int n_bad = 0;

  int         cyc = 0;
  int         st_cyc[$];
  logic [7:0] st_data[$];
  int         ferr_n = 0;
  int         perr_n = 0;
  int         wide_n = 0;
  logic       prev_st = 1'b0, prev_fe = 1'b0, prev_pe = 1'b0;

  uart_receiver #(
    .CLK_FREQ  (6400000),
    .BAUD_RATE (100000),
    .OVERSAMPLE(16)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .UART_RX  (UART_RX),
    .RX_DATA  (RX_DATA),
    .RX_STATUS(RX_STATUS),
    .RX_FERR  (RX_FERR),
    .RX_PERR  (RX_PERR)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc++;

  // Pulse monitor: samples on the falling edge, logs every strobe and
  // counts any strobe that stays high for two consecutive cycles.
  always @(negedge sysclk) begin
    if (RX_STATUS) begin
      st_cyc.push_back(cyc);
      st_data.push_back(RX_DATA);
    end
    if (RX_FERR) ferr_n++;
    if (RX_PERR) perr_n++;
    if ((RX_STATUS && prev_st) || (RX_FERR && prev_fe) || (RX_PERR && prev_pe)) wide_n++;
    prev_st = RX_STATUS;
    prev_fe = RX_FERR;
    prev_pe = RX_PERR;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    UART_RX = b;
    wait_cycles(64);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    UART_RX = 1'b1;
    wait_cycles(5);
    reset = 1'b0;
    @(negedge sysclk);
    n_cmp++; if (RX_DATA !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", RX_DATA); end
    n_cmp++; if (RX_STATUS !== 1'b0) begin n_bad++; $display("FAIL reset_status: got %b expected 0", RX_STATUS); end
    n_cmp++; if (RX_FERR !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b expected 0", RX_FERR); end
    n_cmp++; if (RX_PERR !== 1'b0) begin n_bad++; $display("FAIL reset_perr: got %b expected 0", RX_PERR); end
    wait_cycles(100);
  endtask

  task automatic test_single_frame;
    int b  = st_cyc.size();
    int bf = ferr_n;
    int bp = perr_n;
    send_frame(8'h55, 1'b1);
    send_bit(1'b1);
    n_cmp++; if (st_cyc.size() - b !== 1) begin n_bad++; $display("FAIL single_count: got %0d expected 1", st_cyc.size() - b); end
    else begin
      n_cmp++; if (st_data[b] !== 8'h55) begin n_bad++; $display("FAIL single_data: got %h expected 55", st_data[b]); end
    end
    n_cmp++; if (RX_DATA !== 8'h55) begin n_bad++; $display("FAIL single_port: got %h expected 55", RX_DATA); end
    n_cmp++; if (ferr_n - bf !== 0) begin n_bad++; $display("FAIL single_ferr: got %0d expected 0", ferr_n - bf); end
    n_cmp++; if (perr_n - bp !== 0) begin n_bad++; $display("FAIL single_perr: got %0d expected 0", perr_n - bp); end
  endtask

  task automatic test_back_to_back;
    int b = st_cyc.size();
`ifdef UART_RX_PARITY_EN
    int gap = 704;
`else
    int gap = 640;
`endif
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    send_bit(1'b1);
    n_cmp++; if (st_cyc.size() - b !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d expected 2", st_cyc.size() - b); end
    else begin
      n_cmp++; if (st_data[b] !== 8'hA3) begin n_bad++; $display("FAIL b2b_first: got %h expected a3", st_data[b]); end
      n_cmp++; if (st_data[b+1] !== 8'h0F) begin n_bad++; $display("FAIL b2b_second: got %h expected 0f", st_data[b+1]); end
      n_cmp++; if (st_cyc[b+1] - st_cyc[b] !== gap) begin n_bad++; $display("FAIL b2b_spacing: got %0d expected %0d", st_cyc[b+1] - st_cyc[b], gap); end
    end
  endtask

  task automatic test_glitch;
    int b  = st_cyc.size();
    int bf = ferr_n;
    UART_RX = 1'b0;
    wait_cycles(12);
    UART_RX = 1'b1;
    wait_cycles(200);
    n_cmp++; if (st_cyc.size() - b !== 0) begin n_bad++; $display("FAIL glitch_quiet: got %0d expected 0", st_cyc.size() - b); end
    send_frame(8'h81, 1'b1);
    send_bit(1'b1);
    n_cmp++; if (st_cyc.size() - b !== 1) begin n_bad++; $display("FAIL glitch_count: got %0d expected 1", st_cyc.size() - b); end
    else begin
      n_cmp++; if (st_data[b] !== 8'h81) begin n_bad++; $display("FAIL glitch_data: got %h expected 81", st_data[b]); end
    end
    n_cmp++; if (ferr_n - bf !== 0) begin n_bad++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_n - bf); end
  endtask

  task automatic test_framing_error;
    int b  = st_cyc.size();
    int bf = ferr_n;
    int bp = perr_n;
    send_frame(8'hC4, 1'b0);
    UART_RX = 1'b0;
    wait_cycles(128);
    UART_RX = 1'b1;
    wait_cycles(128);
    n_cmp++; if (ferr_n - bf !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d expected 1", ferr_n - bf); end
    n_cmp++; if (perr_n - bp !== 0) begin n_bad++; $display("FAIL ferr_perr: got %0d expected 0", perr_n - bp); end
    n_cmp++; if (st_cyc.size() - b !== 0) begin n_bad++; $display("FAIL ferr_status: got %0d expected 0", st_cyc.size() - b); end
    n_cmp++; if (RX_DATA !== 8'h81) begin n_bad++; $display("FAIL ferr_data_hold: got %h expected 81", RX_DATA); end
    send_frame(8'h3C, 1'b1);
    send_bit(1'b1);
    n_cmp++; if (st_cyc.size() - b !== 1) begin n_bad++; $display("FAIL ferr_recover_count: got %0d expected 1", st_cyc.size() - b); end
    else begin
      n_cmp++; if (st_data[b] !== 8'h3C) begin n_bad++; $display("FAIL ferr_recover_data: got %h expected 3c", st_data[b]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int b  = st_cyc.size();
    int bf = ferr_n;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    UART_RX = 1'b1;
    wait_cycles(20);
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    @(negedge sysclk);
    n_cmp++; if (RX_DATA !== 8'h00) begin n_bad++; $display("FAIL midrst_data: got %h expected 00", RX_DATA); end
    n_cmp++; if ({RX_STATUS, RX_FERR, RX_PERR} !== 3'b000) begin n_bad++; $display("FAIL midrst_pulses: got %b expected 000", {RX_STATUS, RX_FERR, RX_PERR}); end
    wait_cycles(44);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    n_cmp++; if (st_cyc.size() - b !== 0 || ferr_n - bf !== 0) begin n_bad++; $display("FAIL midrst_abandon: got status %0d ferr %0d expected 0 0", st_cyc.size() - b, ferr_n - bf); end
    send_frame(8'h12, 1'b1);
    send_bit(1'b1);
    n_cmp++; if (st_cyc.size() - b !== 1) begin n_bad++; $display("FAIL midrst_count: got %0d expected 1", st_cyc.size() - b); end
    else begin
      n_cmp++; if (st_data[b] !== 8'h12) begin n_bad++; $display("FAIL midrst_next: got %h expected 12", st_data[b]); end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask

  task automatic test_parity;
    int b  = st_cyc.size();
    int bp = perr_n;
    send_frame_par(8'h07, 1'b1);
    send_bit(1'b1);
    n_cmp++; if (st_cyc.size() - b !== 1) begin n_bad++; $display("FAIL par_good_count: got %0d expected 1", st_cyc.size() - b); end
    else begin
      n_cmp++; if (st_data[b] !== 8'h07) begin n_bad++; $display("FAIL par_good_data: got %h expected 07", st_data[b]); end
    end
    send_frame_par(8'h07, 1'b0);
    send_bit(1'b1);
    n_cmp++; if (perr_n - bp !== 1) begin n_bad++; $display("FAIL par_bad_perr: got %0d expected 1", perr_n - bp); end
    n_cmp++; if (st_cyc.size() - b !== 1) begin n_bad++; $display("FAIL par_bad_status: got %0d expected 1", st_cyc.size() - b); end
    n_cmp++; if (RX_DATA !== 8'h07) begin n_bad++; $display("FAIL par_bad_hold: got %h expected 07", RX_DATA); end
  endtask
`endif

  task automatic test_pulse_shape;
`ifdef UART_RX_PARITY_EN
    int exp_perr = 1;
`else
    int exp_perr = 0;
`endif
    n_cmp++; if (wide_n !== 0) begin n_bad++; $display("FAIL pulse_width: got %0d wide pulses expected 0", wide_n); end
    n_cmp++; if (perr_n !== exp_perr) begin n_bad++; $display("FAIL perr_total: got %0d expected %0d", perr_n, exp_perr); end
  endtask

  initial begin
    reset   = 1'b1;
    UART_RX = 1'b1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_pulse_shape();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
